// File: rtl/cluster_pwr_seq_pkg.sv
// Shared constants for the cluster power sequencer: state codes, register
// offsets and register reset values.
package cluster_pwr_seq_pkg;

  localparam int unsigned STATE_W    = 4;
  localparam int unsigned CFG_ADDR_W = 5;
  localparam int unsigned CFG_DATA_W = 32;

  typedef logic [STATE_W-1:0] seq_state_t;

  localparam seq_state_t ST_OFF     = 4'd0;
  localparam seq_state_t ST_PWR_ON  = 4'd1;
  localparam seq_state_t ST_CLK_ON  = 4'd2;
  localparam seq_state_t ST_RST_REL = 4'd3;
  localparam seq_state_t ST_RUN     = 4'd4;
  localparam seq_state_t ST_DRAIN   = 4'd5;
  localparam seq_state_t ST_RST_ON  = 4'd6;
  localparam seq_state_t ST_CLK_OFF = 4'd7;
  localparam seq_state_t ST_PWR_OFF = 4'd8;

  localparam logic [CFG_ADDR_W-1:0] REG_CTRL    = 5'h00;
  localparam logic [CFG_ADDR_W-1:0] REG_STATUS  = 5'h04;
  localparam logic [CFG_ADDR_W-1:0] REG_BOOT_LO = 5'h08;
  localparam logic [CFG_ADDR_W-1:0] REG_BOOT_HI = 5'h0C;
  localparam logic [CFG_ADDR_W-1:0] REG_PWR_DLY = 5'h10;
  localparam logic [CFG_ADDR_W-1:0] REG_CLK_DLY = 5'h14;
  localparam logic [CFG_ADDR_W-1:0] REG_CFG     = 5'h18;

  localparam int unsigned PWR_DLY_RST = 16;
  localparam int unsigned CLK_DLY_RST = 4;
  localparam logic [63:0] BOOT_RST    = 64'h0000_0000_1C00_8080;
  localparam logic        BYP_RST     = 1'b0;

endpackage

// File: rtl/cluster_pwr_seq_if.sv
// Peripheral config bus between the SoC interconnect and the cluster sequencer.
interface cluster_pwr_seq_if;
  import cluster_pwr_seq_pkg::*;

  logic                  cfg_req_i;
  logic                  cfg_we_i;
  logic [CFG_ADDR_W-1:0] cfg_addr_i;
  logic [CFG_DATA_W-1:0] cfg_wdata_i;
  logic                  cfg_gnt_o;
  logic                  cfg_rvalid_o;
  logic [CFG_DATA_W-1:0] cfg_rdata_o;

  modport master (
    output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o
  );

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o
  );
endinterface

// File: rtl/cluster_pwr_seq_regs.sv
// Config bus decode, staging registers and sticky ERR/TIMEOUT flags.
// START/STOP leave here as single-cycle pulses only when legal for the state.
module cluster_pwr_seq_regs
  import cluster_pwr_seq_pkg::*;
#(
  parameter int unsigned DLY_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cluster_pwr_seq_if.slave     cfg,
  input  seq_state_t           state,
  input  logic                 busy,
  input  logic                 timeout_set,
  output logic                 start_c,
  output logic                 stop_c,
  output logic [DLY_WIDTH-1:0] pwr_dly,
  output logic [DLY_WIDTH-1:0] clk_dly,
  output logic [63:0]          boot_stage,
  output logic                 byp_stage
);

  logic [CFG_ADDR_W-1:0] addr_c;
  logic                  wr_c, rd_c, status_rd_c, err_set_c;
  logic                  req_start_c, req_stop_c;
  logic [CFG_DATA_W-1:0] rd_mux_c;
  logic                  err_q, timeout_q;
  logic                  unused_addr_lsb;

  assign addr_c          = {cfg.cfg_addr_i[CFG_ADDR_W-1:2], 2'b00};
  assign unused_addr_lsb = ^cfg.cfg_addr_i[1:0];
  assign wr_c            = cfg.cfg_req_i & cfg.cfg_we_i;
  assign rd_c            = cfg.cfg_req_i & ~cfg.cfg_we_i;
  assign status_rd_c     = rd_c && (addr_c == REG_STATUS);
  assign req_start_c     = wr_c && (addr_c == REG_CTRL) && cfg.cfg_wdata_i[0];
  assign req_stop_c      = wr_c && (addr_c == REG_CTRL) && cfg.cfg_wdata_i[1];
  assign cfg.cfg_gnt_o   = cfg.cfg_req_i;

  // Legality filter: illegal control writes only raise ERR.
  always_comb begin
    start_c   = 1'b0;
    stop_c    = 1'b0;
    err_set_c = 1'b0;
    if (req_start_c && req_stop_c) begin
      err_set_c = 1'b1;
    end else if (req_start_c) begin
      if (state == ST_OFF) start_c = 1'b1;
      else                 err_set_c = 1'b1;
    end else if (req_stop_c) begin
      if (state == ST_RUN) stop_c = 1'b1;
      else                 err_set_c = 1'b1;
    end
  end

  always_comb begin
    rd_mux_c = '0;
    case (addr_c)
      REG_STATUS:  rd_mux_c = CFG_DATA_W'({timeout_q, err_q, busy, state});
      REG_BOOT_LO: rd_mux_c = boot_stage[31:0];
      REG_BOOT_HI: rd_mux_c = boot_stage[63:32];
      REG_PWR_DLY: rd_mux_c = CFG_DATA_W'(pwr_dly);
      REG_CLK_DLY: rd_mux_c = CFG_DATA_W'(clk_dly);
      REG_CFG:     rd_mux_c = CFG_DATA_W'(byp_stage);
      default:     rd_mux_c = '0;
    endcase
  end

  // A flag raised in the same cycle as a STATUS read survives the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg.cfg_rvalid_o <= 1'b0;
      cfg.cfg_rdata_o  <= '0;
      err_q            <= 1'b0;
      timeout_q        <= 1'b0;
      pwr_dly          <= DLY_WIDTH'(PWR_DLY_RST);
      clk_dly          <= DLY_WIDTH'(CLK_DLY_RST);
      boot_stage       <= BOOT_RST;
      byp_stage        <= BYP_RST;
    end else begin
      cfg.cfg_rvalid_o <= cfg.cfg_req_i;
      cfg.cfg_rdata_o  <= rd_c ? rd_mux_c : '0;
      err_q            <= (err_q & ~status_rd_c) | err_set_c;
      timeout_q        <= (timeout_q & ~status_rd_c) | timeout_set;
      if (wr_c) begin
        case (addr_c)
          REG_BOOT_LO: boot_stage[31:0]  <= cfg.cfg_wdata_i;
          REG_BOOT_HI: boot_stage[63:32] <= cfg.cfg_wdata_i;
          REG_PWR_DLY: pwr_dly           <= cfg.cfg_wdata_i[DLY_WIDTH-1:0];
          REG_CLK_DLY: clk_dly           <= cfg.cfg_wdata_i[DLY_WIDTH-1:0];
          REG_CFG:     byp_stage         <= cfg.cfg_wdata_i[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/cluster_pwr_seq.sv
// Cluster power-up/boot and drain/power-down sequencer.
// Optional drain watchdog: define CLUSTER_SEQ_DRAIN_TIMEOUT_EN.
module cluster_pwr_seq
  import cluster_pwr_seq_pkg::*;
#(
  parameter int unsigned DLY_WIDTH     = 16,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cluster_pwr_seq_if.slave cfg,
  input  logic             cluster_busy_i,
  output logic             cluster_pow_o,
  output logic             cluster_clk_en_o,
  output logic             cluster_rstn_o,
  output logic             cluster_fetch_enable_o,
  output logic [63:0]      cluster_boot_addr_o,
  output logic             cluster_byp_o,
  output logic             seq_evt_o
);

  seq_state_t           state, state_next;
  logic [DLY_WIDTH-1:0] cnt, cnt_next;
  logic                 idle_q, idle_next, busy_q;
  logic                 start_c, stop_c, timeout_set_c, load_shadow_c;
  logic                 pow_next, clk_en_next, rstn_next, fetch_next, evt_next;
  logic [DLY_WIDTH-1:0] pwr_dly, clk_dly;
  logic [63:0]          boot_stage;
  logic                 byp_stage;

  cluster_pwr_seq_regs #(.DLY_WIDTH(DLY_WIDTH)) u_regs (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cfg         (cfg),
    .state       (state),
    .busy        (cluster_busy_i),
    .timeout_set (timeout_set_c),
    .start_c     (start_c),
    .stop_c      (stop_c),
    .pwr_dly     (pwr_dly),
    .clk_dly     (clk_dly),
    .boot_stage  (boot_stage),
    .byp_stage   (byp_stage)
  );

  // A programmed delay of zero counts as one cycle.
  function automatic logic [DLY_WIDTH-1:0] dly_load(input logic [DLY_WIDTH-1:0] d);
    return (d == '0) ? DLY_WIDTH'(1) : d;
  endfunction

`ifdef CLUSTER_SEQ_DRAIN_TIMEOUT_EN
  localparam int unsigned DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drain_cnt <= '0;
    else         drain_cnt <= drain_cnt_next;
  end
`else
  logic unused_drain_timeout;
  assign unused_drain_timeout = ^32'(DRAIN_TIMEOUT);
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    idle_next     = 1'b0;
    timeout_set_c = 1'b0;
`ifdef CLUSTER_SEQ_DRAIN_TIMEOUT_EN
    drain_cnt_next = '0;
`endif
    case (state)
      ST_OFF: if (start_c) begin
        state_next = ST_PWR_ON;
        cnt_next   = dly_load(pwr_dly);
      end
      ST_PWR_ON: if (cnt == DLY_WIDTH'(1)) begin
        state_next = ST_CLK_ON;
        cnt_next   = dly_load(clk_dly);
      end else begin
        cnt_next = cnt - DLY_WIDTH'(1);
      end
      ST_CLK_ON: if (cnt == DLY_WIDTH'(1)) state_next = ST_RST_REL;
                 else                      cnt_next   = cnt - DLY_WIDTH'(1);
      ST_RST_REL: state_next = ST_RUN;
      ST_RUN:     if (stop_c) state_next = ST_DRAIN;
      ST_DRAIN: begin
        // busy_q adds one cycle before idle qualification begins.
        idle_next = ~busy_q;
        if (!busy_q && idle_q) state_next = ST_RST_ON;
`ifdef CLUSTER_SEQ_DRAIN_TIMEOUT_EN
        drain_cnt_next = drain_cnt + DRAIN_W'(1);
        if (state_next == ST_DRAIN && drain_cnt == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
          state_next    = ST_RST_ON;
          timeout_set_c = 1'b1;
        end
`endif
      end
      ST_RST_ON: begin
        state_next = ST_CLK_OFF;
        cnt_next   = dly_load(clk_dly);
      end
      ST_CLK_OFF: if (cnt == DLY_WIDTH'(1)) state_next = ST_PWR_OFF;
                  else                      cnt_next   = cnt - DLY_WIDTH'(1);
      ST_PWR_OFF: state_next = ST_OFF;
      default:    state_next = ST_OFF;
    endcase

    pow_next      = (state_next >= ST_PWR_ON) && (state_next <= ST_CLK_OFF);
    clk_en_next   = (state_next >= ST_CLK_ON) && (state_next <= ST_RST_ON);
    rstn_next     = (state_next >= ST_RST_REL) && (state_next <= ST_DRAIN);
    fetch_next    = (state_next == ST_RUN);
    evt_next      = (state_next != state) &&
                    ((state_next == ST_RUN) || (state_next == ST_OFF));
    load_shadow_c = (state == ST_OFF) && (state_next == ST_PWR_ON);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state                  <= ST_OFF;
      cnt                    <= '0;
      idle_q                 <= 1'b0;
      busy_q                 <= 1'b0;
      cluster_pow_o          <= 1'b0;
      cluster_clk_en_o       <= 1'b0;
      cluster_rstn_o         <= 1'b0;
      cluster_fetch_enable_o <= 1'b0;
      cluster_boot_addr_o    <= '0;
      cluster_byp_o          <= 1'b0;
      seq_evt_o              <= 1'b0;
    end else begin
      state                  <= state_next;
      cnt                    <= cnt_next;
      idle_q                 <= idle_next;
      busy_q                 <= cluster_busy_i;
      cluster_pow_o          <= pow_next;
      cluster_clk_en_o       <= clk_en_next;
      cluster_rstn_o         <= rstn_next;
      cluster_fetch_enable_o <= fetch_next;
      seq_evt_o              <= evt_next;
      if (load_shadow_c) begin
        cluster_boot_addr_o <= boot_stage;
        cluster_byp_o       <= byp_stage;
      end
    end
  end

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Randomized scoreboard bench for cluster_pwr_seq: the model predicts the
// cycle of every cluster-output change and every bus response.
module tb_cluster_pwr_seq;
  import cluster_pwr_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy = 1'b0;
  logic        pow, clk_en, rstn, fetch, byp, evt;
  logic [63:0] boot_addr;

  cluster_pwr_seq_if cfg_if ();

  cluster_pwr_seq dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .cfg                    (cfg_if),
    .cluster_busy_i         (busy),
    .cluster_pow_o          (pow),
    .cluster_clk_en_o       (clk_en),
    .cluster_rstn_o         (rstn),
    .cluster_fetch_enable_o (fetch),
    .cluster_boot_addr_o    (boot_addr),
    .cluster_byp_o          (byp),
    .seq_evt_o              (evt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [4:0] vec; } ev_t;
  typedef struct { logic [31:0] data; logic [4:0] addr; } rd_t;
  ev_t ev_q[$];
  rd_t rd_q[$];

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [4:0] prev_vec = '0;

  logic        m_err = 1'b0;
  logic        m_tout = 1'b0;
  logic [31:0] m_lo = 32'h1C00_8080, m_hi = 32'h0;
  logic        m_byp = 1'b0;

  // Output vector order: {pow, clk_en, rstn, fetch, evt}.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [4:0] vec;
      vec = {pow, clk_en, rstn, fetch, evt};
      if (vec !== prev_vec) begin
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL seq_unexpected cyc=%0d got=%b", cyc, vec);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          if (e.vec !== vec || e.cyc != cyc) begin
            errors++;
            $display("FAIL seq_step got cyc=%0d vec=%b required cyc=%0d vec=%b",
                     cyc, vec, e.cyc, e.vec);
          end
        end
        prev_vec = vec;
      end
      checks++;
      if (cfg_if.cfg_gnt_o !== cfg_if.cfg_req_i) begin
        errors++;
        $display("FAIL gnt cyc=%0d got=%b required=%b", cyc, cfg_if.cfg_gnt_o, cfg_if.cfg_req_i);
      end
      if (cfg_if.cfg_rvalid_o === 1'b1) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected cyc=%0d", cyc);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          if (cfg_if.cfg_rdata_o !== r.data) begin
            errors++;
            $display("FAIL rdata addr=%h cyc=%0d got=%h required=%h",
                     r.addr, cyc, cfg_if.cfg_rdata_o, r.data);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus(input logic we, input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] exp);
    rd_q.push_back('{data: exp, addr: a});
    cfg_if.cfg_req_i   = 1'b1;
    cfg_if.cfg_we_i    = we;
    cfg_if.cfg_addr_i  = a;
    cfg_if.cfg_wdata_i = d;
    tick(1);
    cfg_if.cfg_req_i = 1'b0;
    cfg_if.cfg_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 32'h0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    bus(1'b0, a, 32'h0, exp);
  endtask

  task automatic read_status(input int st);
    logic [31:0] exp;
    exp = {25'd0, m_tout, m_err, busy, 4'(st)};
    m_err  = 1'b0;
    m_tout = 1'b0;
    rd(REG_STATUS, exp);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  task automatic push_ev(input int c, input logic [4:0] v);
    ev_q.push_back('{cyc: c, vec: v});
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {59'd0, pow, clk_en, rstn, fetch, evt}, 64'd0);
    chk({nm, "_boot"}, boot_addr, 64'd0);
    chk({nm, "_byp_rvalid"}, {62'd0, byp, cfg_if.cfg_rvalid_o}, 64'd0);
  endtask

  initial begin
    int p, c, pe, ce, n, s, b, h;
    logic [31:0] new_lo;
    cfg_if.cfg_req_i   = 1'b0;
    cfg_if.cfg_we_i    = 1'b0;
    cfg_if.cfg_addr_i  = '0;
    cfg_if.cfg_wdata_i = '0;
    tick(2);
    chk_all_zero("reset");
    rst_n = 1'b1;
    prev_vec = '0;
    mon_en = 1'b1;
    tick(1);

    read_status(0);
    rd(REG_BOOT_LO, 32'h1C00_8080);
    rd(REG_BOOT_HI, 32'h0);
    rd(REG_PWR_DLY, 32'd16);
    rd(REG_CLK_DLY, 32'd4);
    rd(5'h1C, 32'h0);

    for (int it = 0; it < 6; it++) begin
      p = (it == 0) ? 3 : (it == 1) ? 0 : int'($urandom_range(0, 6));
      c = (it == 0) ? 2 : (it == 1) ? 0 : int'($urandom_range(0, 6));
      pe = (p == 0) ? 1 : p;
      ce = (c == 0) ? 1 : c;
      m_hi  = (it == 0) ? 32'h1 : $urandom;
      m_lo  = (it == 0) ? 32'h2000 : $urandom;
      m_byp = 1'($urandom_range(0, 1));
      wr(REG_BOOT_LO, m_lo);
      wr(REG_BOOT_HI, m_hi);
      wr(REG_PWR_DLY, 32'(p));
      wr(REG_CLK_DLY, 32'(c));
      wr(REG_CFG, {31'd0, m_byp});
      rd(REG_PWR_DLY, 32'(p));
      rd(REG_CFG, {31'd0, m_byp});
      if ($urandom_range(0, 1) == 1) begin
        wr(REG_CTRL, 32'h2);
        m_err = 1'b1;
      end
      read_status(0);

      // Power-up: START in cycle n.
      n = cyc;
      push_ev(n + 1, 5'b10000);
      push_ev(n + 1 + pe, 5'b11000);
      push_ev(n + 1 + pe + ce, 5'b11100);
      push_ev(n + 2 + pe + ce, 5'b11111);
      push_ev(n + 3 + pe + ce, 5'b11110);
      wr(REG_CTRL, 32'h1);
      tick(pe + ce + 3);
      chk("boot_addr_run", boot_addr, {m_hi, m_lo});
      chk("byp_run", {63'd0, byp}, {63'd0, m_byp});

      new_lo = (it == 0) ? 32'h0 : $urandom;
      wr(REG_BOOT_LO, new_lo);
      wr(REG_CTRL, (it % 2 == 0) ? 32'h1 : 32'h3);
      m_err = 1'b1;
      read_status(4);
      read_status(4);
      rd(REG_BOOT_LO, new_lo);
      chk("boot_addr_hold", boot_addr, {m_hi, m_lo});
      m_lo = new_lo;

      // Drain and power-down.
      busy = 1'b1;
      tick(1 + int'($urandom_range(0, 3)));
      s = cyc;
      push_ev(s + 1, 5'b11100);
      wr(REG_CTRL, 32'h2);
      h = (it == 0) ? 9 : int'($urandom_range(1, 10));
      tick(h);
      if (it > 0 && $urandom_range(0, 1) == 1) begin
        busy = 1'b0;
        tick(1);
        busy = 1'b1;
        tick(2);
      end
      read_status(5);
      b = cyc;
      busy = 1'b0;
      push_ev(b + 3, 5'b11000);
      push_ev(b + 4, 5'b10000);
      push_ev(b + 4 + ce, 5'b00000);
      push_ev(b + 5 + ce, 5'b00001);
      push_ev(b + 6 + ce, 5'b00000);
      tick(ce + 8);
      read_status(0);
    end

`ifdef CLUSTER_SEQ_DRAIN_TIMEOUT_EN
    wr(REG_PWR_DLY, 32'd1);
    wr(REG_CLK_DLY, 32'd1);
    n = cyc;
    push_ev(n + 1, 5'b10000);
    push_ev(n + 2, 5'b11000);
    push_ev(n + 3, 5'b11100);
    push_ev(n + 4, 5'b11111);
    push_ev(n + 5, 5'b11110);
    wr(REG_CTRL, 32'h1);
    tick(6);
    busy = 1'b1;
    s = cyc;
    push_ev(s + 1, 5'b11100);
    push_ev(s + 1025, 5'b11000);
    push_ev(s + 1026, 5'b10000);
    push_ev(s + 1027, 5'b00000);
    push_ev(s + 1028, 5'b00001);
    push_ev(s + 1029, 5'b00000);
    wr(REG_CTRL, 32'h2);
    tick(1035);
    m_tout = 1'b1;
    read_status(0);
    busy = 1'b0;
    tick(2);
`endif

    // Asynchronous reset in the middle of power-up.
    wr(REG_PWR_DLY, 32'd8);
    n = cyc;
    push_ev(n + 1, 5'b10000);
    wr(REG_CTRL, 32'h1);
    tick(2);
    chk("pow_before_reset", {63'd0, pow}, 64'd1);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick(1);
    rst_n = 1'b1;
    prev_vec = '0;
    m_err = 1'b0;
    mon_en = 1'b1;
    tick(1);
    rd(REG_PWR_DLY, 32'd16);
    read_status(0);
    tick(3);

    chk("ev_q_drained", 64'(ev_q.size()), 64'd0);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
